// File: rtl/dps_pkg.sv
// Shared types and helpers for the data_pattern_source block.
// Holds the beat-mode and FSM state encodings plus the Galois LFSR step.
// The LFSR step works on a fixed maximum width; callers zero-extend and truncate.
package dps_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest DATA_W the LFSR helper supports.
    localparam int LFSR_MAX_W = 64;

    // One Galois step. Upper bits above the caller's width must be zero so
    // the right shift feeds a zero into the caller's MSB.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] v,
        input logic [LFSR_MAX_W-1:0] poly
    );
        return (v >> 1) ^ (v[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/dps_beat_gen.sv
// Generated-beat source for CONST/COUNT/LFSR modes.
// Ports: clk/rst_n; load_i latches mode_i/seed_i; adv_i steps to the next beat;
//        first_o is beat 0 (combinational from mode_i/seed_i), next_o the beat after the last one issued.
module dps_beat_gen
    import dps_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CONST_PAT = 'hAA,
    parameter logic [DATA_W-1:0] LFSR_POLY = 'hB8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] first_o,
    output logic [DATA_W-1:0] next_o
);

    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] gen_q, gen_d;

    function automatic logic [DATA_W-1:0] succ(input mode_e m, input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        case (m)
            MODE_CONST: r = CONST_PAT;
            MODE_COUNT: r = v + DATA_W'(1);
            MODE_LFSR:  r = DATA_W'(lfsr_next(LFSR_MAX_W'(v), LFSR_MAX_W'(LFSR_POLY)));
            default:    r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        case (mode_e'(mode_i))
            MODE_CONST: first_o = CONST_PAT;
            // An all-zero LFSR state would lock up, so it is replaced by 1.
            MODE_LFSR:  first_o = (seed_i == '0) ? DATA_W'(1) : seed_i;
            default:    first_o = seed_i;
        endcase
    end

    // gen_q always holds the value of the beat following the one most
    // recently loaded into the output slice.
    always_comb begin
        mode_d = mode_q;
        gen_d  = gen_q;
        if (load_i) begin
            mode_d = mode_e'(mode_i);
            gen_d  = succ(mode_e'(mode_i), first_o);
        end else if (adv_i) begin
            gen_d  = succ(mode_q, gen_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_PASS;
            gen_q  <= '0;
        end else begin
            mode_q <= mode_d;
            gen_q  <= gen_d;
        end
    end

    assign next_o = gen_q;

endmodule

// File: rtl/data_pattern_source.sv
// Registered burst data source: PASS (in_data), CONST, COUNT or LFSR beats, burst_len per start.
// Ports: clk, rst_n (async active-low); start/mode/seed/burst_len burst control; in_valid/in_ready/in_data
//        PASS input; out_valid/out_ready/out_data output slice; busy, done status.
// Optional: DPS_CHECKSUM_EN adds checksum output (XOR of all handshaked beats of the burst).
module data_pattern_source
    import dps_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 BURST_W   = 8,
    parameter logic [DATA_W-1:0]  CONST_PAT = 'hAA,
    parameter logic [DATA_W-1:0]  LFSR_POLY = 'hB8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  seed,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done
`ifdef DPS_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  checksum
`endif
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] issued_q, issued_d;   // beats loaded into the output slice
    logic [BURST_W-1:0] hs_cnt_q, hs_cnt_d;   // beats handshaked downstream
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               load;
    logic               hs;
    logic               last_hs;
    logic               slot_free;
    logic               more;
    logic               gen_issue;
    logic               pass_issue;
    logic               in_ready_c;
    logic [DATA_W-1:0]  gen_first;
    logic [DATA_W-1:0]  gen_next;

    assign load      = (state_q == IDLE) && start;
    assign hs        = out_valid_q && out_ready;
    assign last_hs   = hs && (hs_cnt_q == len_q - BURST_W'(1));
    assign slot_free = !out_valid_q || out_ready;
    assign more      = issued_q < len_q;
    assign in_ready_c = (state_q == RUN) && (mode_q == MODE_PASS) && more && slot_free;
    assign gen_issue  = (state_q == RUN) && (mode_q != MODE_PASS) && more && slot_free;
    assign pass_issue = in_ready_c && in_valid;

    dps_beat_gen #(
        .DATA_W    (DATA_W),
        .CONST_PAT (CONST_PAT),
        .LFSR_POLY (LFSR_POLY)
    ) u_beat_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .mode_i  (mode),
        .seed_i  (seed),
        .adv_i   (gen_issue),
        .first_o (gen_first),
        .next_o  (gen_next)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        issued_d    = issued_q;
        hs_cnt_d    = hs_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode_e'(mode);
                    len_d    = burst_len;
                    issued_d = '0;
                    hs_cnt_d = '0;
                    if (burst_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        // Generated modes preload beat 0 so it is valid the next cycle.
                        if (mode_e'(mode) != MODE_PASS) begin
                            out_valid_d = 1'b1;
                            out_data_d  = gen_first;
                            issued_d    = BURST_W'(1);
                        end
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    hs_cnt_d    = hs_cnt_q + BURST_W'(1);
                    out_valid_d = 1'b0;
                end
                // A new beat may refill the slot in the same cycle it drains.
                if (gen_issue) begin
                    out_valid_d = 1'b1;
                    out_data_d  = gen_next;
                    issued_d    = issued_q + BURST_W'(1);
                end else if (pass_issue) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    issued_d    = issued_q + BURST_W'(1);
                end
                if (last_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_PASS;
            len_q       <= '0;
            issued_q    <= '0;
            hs_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            hs_cnt_q    <= hs_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef DPS_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Only handshakes change it, so it holds from the done pulse until the next start.
    always_comb begin
        csum_d = csum_q;
        if (load) begin
            csum_d = '0;
        end else if (hs) begin
            csum_d = csum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_data_pattern_source.sv
module tb_data_pattern_source;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] burst_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
`ifdef DPS_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks;
    int errors;

    data_pattern_source dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .burst_len (burst_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
`ifdef DPS_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed = 8'h00; burst_len = 8'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_data, in_ready, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h ir=%b busy=%b done=%b, want all 0",
                     out_valid, out_data, in_ready, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives a start pulse at a falling edge; returns at the next falling edge.
    task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [7:0] l);
        mode = m; seed = s; burst_len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_count;
        logic [7:0] exp_d [0:3];
        exp_d[0] = 8'hFE; exp_d[1] = 8'hFF; exp_d[2] = 8'h00; exp_d[3] = 8'h01;
        out_ready = 1'b1;
        do_start(2'd2, 8'hFE, 8'd4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (!(out_valid === 1'b1 && out_data === exp_d[k] && done === 1'b0)) begin
                errors++;
                $display("FAIL count_beat%0d: got v=%b d=%h done=%b, want v=1 d=%h done=0",
                         k, out_valid, out_data, done, exp_d[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (!(done === 1'b1 && out_valid === 1'b0 && busy === 1'b1)) begin
            errors++;
            $display("FAIL count_done: got done=%b v=%b busy=%b, want done=1 v=0 busy=1", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (!(done === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL count_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_const_stall;
        int         hs;
        logic       seen_done;
        logic       prev_stall;
        logic [7:0] prev_d;
        hs = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_d = 8'h00;
        out_ready = 1'b1;
        do_start(2'd1, 8'h00, 8'd3);
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            out_ready = !(cyc == 1 || cyc == 2);
            #1;
            if (prev_stall) begin
                checks++;
                if (!(out_valid === 1'b1 && out_data === prev_d)) begin
                    errors++;
                    $display("FAIL const_hold: got v=%b d=%h, want v=1 d=%h", out_valid, out_data, prev_d);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 8'hAA) begin
                    errors++;
                    $display("FAIL const_data: got %h, want aa", out_data);
                end
                if (out_ready) hs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (!(hs == 3 && seen_done)) begin
            errors++;
            $display("FAIL const_handshakes: got hs=%0d done_seen=%b, want hs=3 done_seen=1", hs, seen_done);
        end
    endtask

    task automatic test_lfsr;
        logic [7:0] exp_d [0:2];
        exp_d[0] = 8'h01; exp_d[1] = 8'hB8; exp_d[2] = 8'h5C;
        out_ready = 1'b1;
        do_start(2'd3, 8'h00, 8'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!(out_valid === 1'b1 && out_data === exp_d[k])) begin
                errors++;
                $display("FAIL lfsr_beat%0d: got v=%b d=%h, want v=1 d=%h", k, out_valid, out_data, exp_d[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (!(done === 1'b1 && out_valid === 1'b0)) begin
            errors++;
            $display("FAIL lfsr_done: got done=%b v=%b, want 1 0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_pass;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11;
        do_start(2'd0, 8'h00, 8'd2);
        #1;
        checks++;
        if (!(in_ready === 1'b1 && out_valid === 1'b0)) begin
            errors++;
            $display("FAIL pass_first_ready: got ir=%b v=%b, want ir=1 v=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_data = 8'h22;
        #1;
        checks++;
        if (!(out_valid === 1'b1 && out_data === 8'h11 && in_ready === 1'b1)) begin
            errors++;
            $display("FAIL pass_beat0: got v=%b d=%h ir=%b, want v=1 d=11 ir=1", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        in_data = 8'h33;
        #1;
        checks++;
        if (!(out_valid === 1'b1 && out_data === 8'h22 && in_ready === 1'b0)) begin
            errors++;
            $display("FAIL pass_beat1: got v=%b d=%h ir=%b, want v=1 d=22 ir=0", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (!(done === 1'b1 && out_valid === 1'b0 && in_ready === 1'b0)) begin
            errors++;
            $display("FAIL pass_done: got done=%b v=%b ir=%b, want 1 0 0", done, out_valid, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (!(out_valid === 1'b0 && in_ready === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL pass_no_extra: got v=%b d=%h ir=%b busy=%b, want v=0 ir=0 busy=0",
                     out_valid, out_data, in_ready, busy);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        out_ready = 1'b1;
        do_start(2'd2, 8'h10, 8'd0);
        checks++;
        if (!(done === 1'b1 && out_valid === 1'b0 && busy === 1'b1)) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b v=%b busy=%b, want 1 0 1", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (!(done === 1'b0 && out_valid === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL zero_len_idle: got done=%b v=%b busy=%b, want 0 0 0", done, out_valid, busy);
        end
    endtask

    task automatic test_start_in_run;
        int beats;
        int k;
        logic seen_done;
        beats = 0; seen_done = 1'b0;
        out_ready = 1'b1;
        do_start(2'd2, 8'h10, 8'd3);
        // A second start with different settings mid-burst must change nothing.
        mode = 2'd1; seed = 8'h55; burst_len = 8'd9; start = 1'b1;
        for (int cyc = 0; cyc < 12 && !seen_done; cyc++) begin
            #1;
            if (out_valid === 1'b1) begin
                k = beats;
                checks++;
                if (out_data !== 8'(8'h10 + k)) begin
                    errors++;
                    $display("FAIL restart_beat%0d: got %h, want %h", k, out_data, 8'(8'h10 + k));
                end
                beats++;
            end
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (!(beats == 3 && seen_done)) begin
            errors++;
            $display("FAIL restart_count: got beats=%0d done_seen=%b, want 3 1", beats, seen_done);
        end
    endtask

    task automatic test_reset_mid_burst;
        int done_cnt;
        done_cnt = 0;
        out_ready = 1'b1;
        do_start(2'd2, 8'h00, 8'd5);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!(out_valid === 1'b1 && out_data === 8'h02)) begin
            errors++;
            $display("FAIL rst_mid_pre: got v=%b d=%h, want v=1 d=02", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, busy, done, in_ready} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b d=%h busy=%b done=%b ir=%b, want all 0",
                     out_valid, out_data, busy, done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d cycles with done/valid after reset, want 0", done_cnt);
        end
    endtask

`ifdef DPS_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] exp_c [0:2];
        exp_c[0] = 8'h00; exp_c[1] = 8'h01; exp_c[2] = 8'h03;
        out_ready = 1'b1;
        do_start(2'd2, 8'h01, 8'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (checksum !== exp_c[k]) begin
                errors++;
                $display("FAIL csum_run%0d: got %h, want %h", k, checksum, exp_c[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (!(done === 1'b1 && checksum === 8'h00)) begin
            errors++;
            $display("FAIL csum_done: got done=%b csum=%h, want done=1 csum=00", done, checksum);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count();
        test_const_stall();
        test_lfsr();
        test_pass();
        test_zero_len();
        test_start_in_run();
        test_reset_mid_burst();
`ifdef DPS_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
